// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
// The step table maps each of the four nibble steps to its operand halves and shift.
package mult_ctrl_pkg;

    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    localparam int NIB_W    = OP_W / 2;
    localparam int PART_W   = 2 * NIB_W;
    localparam int STEP_CNT = 4;
    localparam int STEP_W   = $clog2(STEP_CNT);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_CNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       a_hi;
        logic       b_hi;
        logic [3:0] shift;
    } step_sel_t;

    // step | a nibble | b nibble | shift :  0 L L 0 | 1 H L 4 | 2 L H 4 | 3 H H 8
    function automatic step_sel_t step_sel(input logic [STEP_W-1:0] step);
        step_sel_t s;
        case (step)
            2'd0:    s = '{a_hi: 1'b0, b_hi: 1'b0, shift: 4'd0};
            2'd1:    s = '{a_hi: 1'b1, b_hi: 1'b0, shift: 4'd4};
            2'd2:    s = '{a_hi: 1'b0, b_hi: 1'b1, shift: 4'd4};
            default: s = '{a_hi: 1'b1, b_hi: 1'b1, shift: 4'd8};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seq_mult8_ctrl_if.sv
// Operand/product handshake bundle for seq_mult8_ctrl.
// master = producer/consumer side, slave = the multiplier block.
interface seq_mult8_ctrl_if;
    import mult_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p;

    modport master (
        output in_valid, a, b, abort, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, abort, out_ready,
        output in_ready, out_valid, p
    );

endinterface

// File: rtl/array_multiplier_gen.sv
// Combinational unsigned WxW array multiplier built from AND rows and adders.
module array_multiplier_gen #(
    parameter int W = 4
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] prod
);

    always_comb begin
        prod = '0;
        for (int i = 0; i < W; i++) begin
            prod = prod + (({{W{1'b0}}, x & {W{y[i]}}}) << i);
        end
    end

endmodule

// File: rtl/seq_mult8_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 array multiplier shared over four
// nibble steps, accumulating into a 16-bit register, with valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready=1
//   MUL   | one nibble step per cycle, abort returns to IDLE
//   DONE  | product held on p with out_valid=1 until out_ready
module seq_mult8_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_mult8_ctrl_if.slave  bus
);

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   step;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                zero_q;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   p_q;
    logic [PROD_W-1:0]   partial;
    logic [PROD_W-1:0]   acc_sum;
    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [PART_W-1:0]   part;
    step_sel_t           sel;
    logic                accept;
    logic                skip;

    assign accept = (state == IDLE) && bus.in_valid;
    assign skip   = ZERO_SKIP && zero_q;

    assign sel     = step_sel(step);
    assign nib_a   = sel.a_hi ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
    assign nib_b   = sel.b_hi ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

    array_multiplier_gen #(.W(NIB_W)) u_mul (
        .x    (nib_a),
        .y    (nib_b),
        .prod (part)
    );

    assign partial = {{(PROD_W-PART_W){1'b0}}, part} << sel.shift;
    assign acc_sum = acc + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = MUL;
            MUL: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (skip || (step == LAST_STEP)) begin
                    state_nxt = DONE;
                end
            end
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // p_q keeps the last completed product while acc is reused by the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            zero_q <= 1'b0;
            acc    <= '0;
            step   <= '0;
            p_q    <= '0;
        end else if (accept) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            zero_q <= (bus.a == '0) || (bus.b == '0);
            acc    <= '0;
            step   <= '0;
        end else if (state == MUL) begin
            if (bus.abort) begin
                acc  <= '0;
                step <= '0;
            end else if (skip) begin
                p_q  <= '0;
            end else begin
                acc  <= acc_sum;
                step <= step + 1'b1;
                if (step == LAST_STEP) begin
                    p_q <= acc_sum;
                end
            end
        end
    end

    assign bus.p = p_q;

endmodule
